// File: rtl/qf_aff2_wr_arb.sv
// qf_aff2_wr_arb: round-robin arbiter sharing the qf_aff2 FIFO write port.
// Optional stall counter built when QF_AFF2_WR_ARB_STALL_CNT_EN is defined.
module qf_aff2_wr_arb #(
  parameter int PAR_REQ_NUM         = 4,
  parameter int PAR_FIFO_DATA_WIDTH = 32,
  parameter bit PAR_DLY             = 1'b1
) (
  input  logic                                       arb_clk,
  input  logic                                       arb_rst,
  input  logic [PAR_REQ_NUM-1:0]                     req,
  input  logic [PAR_REQ_NUM*PAR_FIFO_DATA_WIDTH-1:0] req_data,
  output logic [PAR_REQ_NUM-1:0]                     gnt,
  input  logic                                       fifo_full_flag_wrclk,
  output logic                                       fifo_wr_en,
  output logic [PAR_FIFO_DATA_WIDTH-1:0]             fifo_wr_data,
  output logic                                       busy,
  input  logic                                       stall_cnt_clr,
  output logic [15:0]                                stall_cnt
);

  localparam int W  = PAR_FIFO_DATA_WIDTH;
  localparam int IW = (PAR_REQ_NUM > 1) ? $clog2(PAR_REQ_NUM) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(PAR_REQ_NUM - 1);
  // flops are written without an intra-assignment delay
  localparam bit dly_unused = PAR_DLY;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FULL,
    ST_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    arb_idx, cand, sel;
  logic             arb_hit, issue;
  logic [PAR_REQ_NUM-1:0] gnt_d;
  logic             wr_en_d;
  logic [W-1:0]     data_d;
  logic [W-1:0]     req_word [PAR_REQ_NUM];

  // split the flat request data bus into per-requester words
  always_comb begin
    for (int i = 0; i < PAR_REQ_NUM; i++) begin
      req_word[i] = req_data[i*W +: W];
    end
  end

  // round-robin pick: first requester after the last granted one
  always_comb begin
    arb_idx = last_q;
    arb_hit = 1'b0;
    cand    = last_q;
    for (int k = 1; k <= PAR_REQ_NUM; k++) begin
      cand = IW'((int'(last_q) + k) % PAR_REQ_NUM);
      if (!arb_hit && req[cand]) begin
        arb_idx = cand;
        arb_hit = 1'b1;
      end
    end
  end

  // next state and registered-output values
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = '0;
    wr_en_d = 1'b0;
    data_d  = fifo_wr_data;
    issue   = 1'b0;
    sel     = win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          win_d = arb_idx;
          sel   = arb_idx;
          if (fifo_full_flag_wrclk) state_d = ST_WAIT_FULL;
          else issue = 1'b1;
        end
      end
      ST_WAIT_FULL: begin
        if (!fifo_full_flag_wrclk) issue = 1'b1;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (issue) begin
      state_d    = ST_WRITE;
      last_d     = sel;
      wr_en_d    = 1'b1;
      gnt_d[sel] = 1'b1;
      data_d     = req_word[sel];
    end
  end

  // state, pointers and registered outputs
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_RST;
      win_q        <= LAST_RST;
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      gnt          <= gnt_d;
      fifo_wr_en   <= wr_en_d;
      fifo_wr_data <= data_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef QF_AFF2_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // saturating count of cycles spent waiting on a full FIFO
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      stall_q <= 16'h0000;
    end else if (stall_cnt_clr) begin
      stall_q <= 16'h0000;
    end else if (state_q == ST_WAIT_FULL && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic clr_unused;
  assign clr_unused = stall_cnt_clr;
  assign stall_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_qf_aff2_wr_arb.sv
// tb_qf_aff2_wr_arb: scoreboard bench for the FIFO write-port arbiter.
// Expected writes come from a behavioural arbiter model in the stimulus.
module tb_qf_aff2_wr_arb;

  localparam int N = 4;
  localparam int W = 32;
`ifdef QF_AFF2_WR_ARB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           arb_rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           full = 1'b0;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic           busy;
  logic           clr = 1'b0;
  logic [15:0]    stall_cnt;

  qf_aff2_wr_arb #(
    .PAR_REQ_NUM(N),
    .PAR_FIFO_DATA_WIDTH(W),
    .PAR_DLY(1'b1)
  ) dut (
    .arb_clk(clk),
    .arb_rst(arb_rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .fifo_full_flag_wrclk(full),
    .fifo_wr_en(wr_en),
    .fifo_wr_data(wr_data),
    .busy(busy),
    .stall_cnt_clr(clr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] g;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_m, pend_m, rel_m, stall_m;
  bit gap_m;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_m  = N - 1;
    pend_m  = -1;
    gap_m   = 1'b0;
    rel_m   = -1;
    stall_m = 0;
    q.delete();
  endtask

  task automatic issue(int w);
    exp_t e;
    e.cyc  = cyc;
    e.g    = '0;
    e.g[w] = 1'b1;
    e.d    = req_data[w*W +: W];
    q.push_back(e);
    last_m = w;
    gap_m  = 1'b1;
  endtask

  // spec-level arbiter: one word, then a mandatory gap cycle
  task automatic model_step();
    bit was_wait;
    int w;
    was_wait = (pend_m >= 0);
    rel_m = -1;
    if (gap_m) begin
      gap_m = 1'b0;
      rel_m = last_m;
    end else if (pend_m >= 0) begin
      if (!full) begin
        issue(pend_m);
        pend_m = -1;
      end
    end else if (req != '0) begin
      w = rr_pick(req, last_m);
      if (!full) issue(w);
      else pend_m = w;
    end
    if (clr) stall_m = 0;
    else if (was_wait && stall_m < 65535) stall_m++;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!arb_rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    arb_rst = 1'b1;
    model_reset();
    repeat (2) tick();
    arb_rst = 1'b0;
  endtask

  task automatic rand_drive(int pfull);
    for (int i = 0; i < N; i++) begin
      if (!req[i] || i == rel_m) begin
        if ($urandom_range(99) < 40) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = $urandom;
        end else begin
          req[i] = 1'b0;
        end
      end
    end
    full = ($urandom_range(99) < pfull);
    clr  = ($urandom_range(99) < 3);
  endtask

  // monitor: match every presented write against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_write: got none want gnt %0b at cyc %0d",
               q[0].g, q[0].cyc);
      void'(q.pop_front());
    end
    if (wr_en || gnt != '0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got gnt %0b wr_en %0b want none (cyc %0d)",
                 gnt, wr_en, cyc);
      end else begin
        e = q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("gnt", 64'(gnt), 64'(e.g));
        chk("wr_en", 64'(wr_en), 64'd1);
        chk("wr_data", 64'(wr_data), 64'(e.d));
      end
    end
    chk("busy", 64'(busy), 64'((pend_m >= 0) || gap_m));
    chk("stall_cnt", 64'(stall_cnt), STALL_EN ? 64'(stall_m) : 64'd0);
  end

  initial begin
    model_reset();
    #2 arb_rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    tick();
    arb_rst = 1'b0;

    // single write from requester 0
    req = 4'b0001;
    req_data[0 +: W] = 32'hA5A5_0001;
    tick();
    chk("single_gnt", 64'(gnt), 64'h1);
    chk("single_data", 64'(wr_data), 64'hA5A5_0001);
    tick();
    req = '0;
    repeat (3) tick();

    // round robin with all requesters held
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hC0DE_0000 + i;
    req = 4'b1111;
    repeat (10) tick();
    req = '0;
    repeat (3) tick();

    // full stall with a late request arriving during the wait
    full = 1'b1;
    req = 4'b0100;
    req_data[2*W +: W] = 32'h2222_0002;
    repeat (2) tick();
    req[0] = 1'b1;
    req_data[0 +: W] = 32'h0000_0AAA;
    repeat (3) tick();
    chk("stall_no_wr", 64'(wr_en), 64'd0);
    full = 1'b0;
    tick();
    tick();
    req[2] = 1'b0;
    tick();
    tick();
    req[0] = 1'b0;
    repeat (3) tick();

    // reset in the middle of a write
    req = 4'b1111;
    tick();
    @(negedge clk);
    #1 arb_rst = 1'b1;
    #1;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    model_reset();
    repeat (2) tick();
    arb_rst = 1'b0;
    tick();
    chk("prio_after_rst", 64'(gnt), 64'h1);
    repeat (5) tick();
    req = '0;
    repeat (3) tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rand_drive(30);
    end
    req  = '0;
    full = 1'b0;
    clr  = 1'b0;
    repeat (6) tick();

`ifdef QF_AFF2_WR_ARB_STALL_CNT_EN
    // counter saturation and clear
    full = 1'b1;
    req  = 4'b0001;
    repeat (70000) tick();
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("stall_clr", 64'(stall_cnt), 64'h0);
    full = 1'b0;
    tick();
    req = '0;
    repeat (4) tick();
`endif

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
